on_off_toggle_gen: RTL and testbench

- Consumer of the 26-bit `r_change_on_off` half-period word written over Avalon-MM by the host.
- Generates the scanner's periodic ON/OFF control square wave: each phase (ON or OFF) lasts exactly N clocks, where N is the configured value.
- Configuration changes are applied only at phase boundaries, so no runt pulses occur.
- Provides an edge strobe, a completed-cycle counter and a line-synchronous restart for the line-scan timing logic.

---
 rtl/on_off_toggle_gen.sv | 142 ++++++++++++++
 tb/tb_on_off_toggle_gen.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/on_off_toggle_gen.sv
// Periodic ON/OFF square-wave generator. Each phase lasts the configured
// half-period; new settings take effect only at phase boundaries.
module on_off_toggle_gen #(
   parameter int PERIOD_W = 26,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PERIOD_W-1:0] r_change_on_off,
   input  logic                sync_restart,
   output logic                on_off,
   output logic                edge_pulse,
   output logic [CNT_W-1:0]    cycle_count,
   output logic                busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [PERIOD_W-1:0] cfg_r;
   logic [PERIOD_W-1:0] cnt_r;
   logic [PERIOD_W-1:0] cnt_s;
   logic                on_off_r;
   logic                on_off_s;
   logic                edge_r;
   logic                edge_s;
   logic [CNT_W-1:0]    cyc_r;
   logic [CNT_W-1:0]    cyc_s;
   logic                busy_r;
   logic                cfg_zero_s;
   logic                cnt_zero_s;
   logic [PERIOD_W-1:0] reload_s;

   assign cfg_zero_s = (cfg_r == {PERIOD_W{1'b0}});
   assign cnt_zero_s = (cnt_r == {PERIOD_W{1'b0}});
   assign reload_s   = cfg_r - PERIOD_W'(1);

   // Input stage: half-period word sampled every clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_r <= {PERIOD_W{1'b0}};
      end else begin
         cfg_r <= r_change_on_off;
      end
   end

   // State, phase counter and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         cnt_r    <= {PERIOD_W{1'b0}};
         on_off_r <= 1'b0;
         edge_r   <= 1'b0;
         cyc_r    <= {CNT_W{1'b0}};
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         on_off_r <= on_off_s;
         edge_r   <= edge_s;
         cyc_r    <= cyc_s;
         busy_r   <= (state_s != ST_IDLE);
      end
   end

   // Next-state logic; a restart outranks any simultaneous phase boundary.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      on_off_s = on_off_r;
      edge_s   = 1'b0;
      cyc_s    = cyc_r;
      if (sync_restart && !cfg_zero_s) begin
         state_s  = ST_ON;
         cnt_s    = reload_s;
         on_off_s = 1'b1;
         edge_s   = ~on_off_r;
      end else begin
         case (state_r)
            ST_IDLE: begin
               on_off_s = 1'b0;
               cnt_s    = {PERIOD_W{1'b0}};
               if (!cfg_zero_s) begin
                  state_s  = ST_ON;
                  cnt_s    = reload_s;
                  on_off_s = 1'b1;
                  edge_s   = 1'b1;
               end else begin
                  state_s  = ST_IDLE;
               end
            end
            ST_ON: begin
               if (!cnt_zero_s) begin
                  cnt_s = cnt_r - PERIOD_W'(1);
               end else if (cfg_zero_s) begin
                  state_s  = ST_IDLE;
                  on_off_s = 1'b0;
                  edge_s   = 1'b1;
               end else begin
                  state_s  = ST_OFF;
                  cnt_s    = reload_s;
                  on_off_s = 1'b0;
                  edge_s   = 1'b1;
               end
            end
            ST_OFF: begin
               if (!cnt_zero_s) begin
                  cnt_s = cnt_r - PERIOD_W'(1);
               end else if (cfg_zero_s) begin
                  // Wave is already low, so stopping here produces no edge.
                  state_s  = ST_IDLE;
                  on_off_s = 1'b0;
                  edge_s   = 1'b0;
               end else begin
                  state_s  = ST_ON;
                  cnt_s    = reload_s;
                  on_off_s = 1'b1;
                  edge_s   = 1'b1;
                  cyc_s    = cyc_r + CNT_W'(1);
               end
            end
            default: begin
               state_s  = ST_IDLE;
               cnt_s    = {PERIOD_W{1'b0}};
               on_off_s = 1'b0;
               edge_s   = 1'b0;
            end
         endcase
      end
   end

   assign on_off      = on_off_r;
   assign edge_pulse  = edge_r;
   assign cycle_count = cyc_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_on_off_toggle_gen.sv
// Directed bench for on_off_toggle_gen: hand-computed per-clock expectations
// for on_off/edge_pulse plus spot checks of cycle_count and busy.
module tb_on_off_toggle_gen;

   localparam int PERIOD_W = 26;
   localparam int CNT_W    = 16;

   logic                clk;
   logic                reset;
   logic [PERIOD_W-1:0] r_change_on_off;
   logic                sync_restart;
   logic                on_off;
   logic                edge_pulse;
   logic [CNT_W-1:0]    cycle_count;
   logic                busy;

   int vec_cnt;
   int err_cnt;

   on_off_toggle_gen #(
      .PERIOD_W(PERIOD_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .r_change_on_off(r_change_on_off),
      .sync_restart   (sync_restart),
      .on_off         (on_off),
      .edge_pulse     (edge_pulse),
      .cycle_count    (cycle_count),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expectation literals are written in time order: leftmost bit is the first clock.
   task automatic run_vec(input string tag, input int n, input logic [31:0] on_exp,
                          input logic [31:0] edge_exp);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_vec({tag, "_on"}, {31'd0, on_off}, {31'd0, on_exp[n-1-i]});
         check_vec({tag, "_edge"}, {31'd0, edge_pulse}, {31'd0, edge_exp[n-1-i]});
      end
   endtask

   task automatic chk_cyc_busy(input string tag, input logic [31:0] cyc_exp, input logic busy_exp);
      check_vec({tag, "_cyc"}, {16'd0, cycle_count}, cyc_exp);
      check_vec({tag, "_busy"}, {31'd0, busy}, {31'd0, busy_exp});
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_vec({tag, "_rst_on"}, {31'd0, on_off}, 32'd0);
      check_vec({tag, "_rst_edge"}, {31'd0, edge_pulse}, 32'd0);
      chk_cyc_busy({tag, "_rst"}, 32'd0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      vec_cnt         = 0;
      err_cnt         = 0;
      reset           = 1'b1;
      r_change_on_off = 26'd0;
      sync_restart    = 1'b0;
      #1;
      check_vec("init_on", {31'd0, on_off}, 32'd0);
      chk_cyc_busy("init", 32'd0, 1'b0);

      // Reset mid-ON with N=5, after one full cycle has completed
      r_change_on_off = 26'd5;
      do_reset("a0");
      run_vec("a_run", 13, 32'b0111110000011, 32'b0100001000010);
      chk_cyc_busy("a_pre", 32'd1, 1'b1);
      do_reset("a1");
      run_vec("a_resume", 3, 32'b011, 32'b010);
      chk_cyc_busy("a_post", 32'd0, 1'b1);

      // N=3 written from IDLE, then switched to N=1
      r_change_on_off = 26'd0;
      do_reset("b");
      run_vec("b_idle", 2, 32'b00, 32'b00);
      chk_cyc_busy("b_idle", 32'd0, 1'b0);
      r_change_on_off = 26'd3;
      run_vec("b_n3", 8, 32'b01110001, 32'b01001001);
      chk_cyc_busy("b_n3", 32'd1, 1'b1);
      r_change_on_off = 26'd1;
      run_vec("b_n1", 8, 32'b11010101, 32'b00111111);
      chk_cyc_busy("b_n1a", 32'd4, 1'b1);
      run_vec("b_n1b", 4, 32'b0101, 32'b1111);
      chk_cyc_busy("b_n1b", 32'd6, 1'b1);

      // N changes 4->2 on the first clock of ON
      r_change_on_off = 26'd4;
      do_reset("c");
      run_vec("c_start", 2, 32'b01, 32'b01);
      r_change_on_off = 26'd2;
      run_vec("c_chg", 8, 32'b11100110, 32'b00010101);
      chk_cyc_busy("c", 32'd1, 1'b1);

      // N set to 0 during OFF, then during ON
      r_change_on_off = 26'd3;
      do_reset("d");
      run_vec("d_run", 5, 32'b01110, 32'b01001);
      r_change_on_off = 26'd0;
      run_vec("d_off0a", 2, 32'b00, 32'b00);
      chk_cyc_busy("d_offa", 32'd0, 1'b1);
      run_vec("d_off0b", 2, 32'b00, 32'b00);
      chk_cyc_busy("d_offb", 32'd0, 1'b0);
      r_change_on_off = 26'd3;
      run_vec("d_on", 2, 32'b01, 32'b01);
      r_change_on_off = 26'd0;
      run_vec("d_on0", 4, 32'b1100, 32'b0010);
      chk_cyc_busy("d_on0", 32'd0, 1'b0);

      // sync_restart on OFF clock 2, then during ON, with N=6
      r_change_on_off = 26'd6;
      do_reset("e");
      run_vec("e_run", 9, 32'b011111100, 32'b010000010);
      sync_restart = 1'b1;
      run_vec("e_rs_off", 1, 32'b1, 32'b1);
      sync_restart = 1'b0;
      chk_cyc_busy("e_rs_off", 32'd0, 1'b1);
      run_vec("e_on6", 6, 32'b111110, 32'b000001);
      run_vec("e_off6", 6, 32'b000001, 32'b000001);
      chk_cyc_busy("e_cyc1", 32'd1, 1'b1);
      run_vec("e_on2", 1, 32'b1, 32'b0);
      sync_restart = 1'b1;
      run_vec("e_rs_on", 1, 32'b1, 32'b0);
      sync_restart = 1'b0;
      run_vec("e_ext", 6, 32'b111110, 32'b000001);
      chk_cyc_busy("e_end", 32'd1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
